// File: rtl/dcache_victim_buffer.sv
// Write-back victim buffer: absorbs dirty-line evictions into a small FIFO, serves
// read hits from it, forwards read misses to memory and drains lines when idle.
module dcache_victim_buffer #(
  parameter int DEPTH    = 4,
  parameter int S_OFFSET = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  cache_address,
  input  logic         cache_read,
  input  logic         cache_write,
  input  logic [255:0] cache_wdata,
  output logic [255:0] cache_rdata,
  output logic         cache_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 32 - S_OFFSET;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP     = 2'd1,
    MEM_READ = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t         state_r;
  logic [TW-1:0]  tag_r  [DEPTH];
  logic [255:0]   data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [CW-1:0]  count_r;
  logic           resp_r;
  logic           pmem_read_r;
  logic           pmem_write_r;
  logic [31:0]    pmem_address_r;
  logic [255:0]   pmem_wdata_r;
  logic [255:0]   rdata_r;

  logic [TW-1:0]    req_tag_s;
  logic             unused_offset_s;
  logic             full_s;
  logic             empty_s;
  logic [DEPTH-1:0] hit_vec_s;
  logic [PW-1:0]    hit_idx_s;
  logic             hit_s;
  logic             wr_en_s;
  logic [PW-1:0]    wr_idx_s;

  assign req_tag_s       = cache_address[31:S_OFFSET];
  assign unused_offset_s = ^cache_address[S_OFFSET-1:0];
  assign full_s          = (count_r == CW'(DEPTH));
  assign empty_s         = (count_r == {CW{1'b0}});

  // Tag match across all entries; at most one entry can match, so OR-ing indices is exact.
  always_comb begin
    hit_vec_s = {DEPTH{1'b0}};
    hit_idx_s = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec_s[i] = valid_r[i] & (tag_r[i] == req_tag_s);
      hit_idx_s    = hit_idx_s | (hit_vec_s[i] ? PW'(i) : {PW{1'b0}});
    end
  end

  assign hit_s = |hit_vec_s;

  // Eviction store target: overwrite a matching line in place, otherwise allocate at tail.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = tail_r;
    if ((state_r == IDLE) && cache_write) begin
      if (hit_s) begin
        wr_en_s  = 1'b1;
        wr_idx_s = hit_idx_s;
      end else if (!full_s) begin
        wr_en_s  = 1'b1;
      end else begin
        wr_en_s  = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Line storage; contents are qualified by valid_r so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tag_r[wr_idx_s]  <= req_tag_s;
      data_r[wr_idx_s] <= cache_wdata;
    end
  end

  // Control FSM, FIFO bookkeeping and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      valid_r        <= {DEPTH{1'b0}};
      head_r         <= {PW{1'b0}};
      tail_r         <= {PW{1'b0}};
      count_r        <= {CW{1'b0}};
      resp_r         <= 1'b0;
      pmem_read_r    <= 1'b0;
      pmem_write_r   <= 1'b0;
      pmem_address_r <= 32'h0000_0000;
      pmem_wdata_r   <= 256'h0;
      rdata_r        <= 256'h0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_r <= 1'b0;
          if (cache_write && (hit_s || !full_s)) begin
            if (!hit_s) begin
              valid_r[tail_r] <= 1'b1;
              tail_r          <= tail_r + 1'b1;
              count_r         <= count_r + 1'b1;
            end
            resp_r  <= 1'b1;
            state_r <= RESP;
          end else if (!cache_write && cache_read && hit_s) begin
            rdata_r <= data_r[hit_idx_s];
            resp_r  <= 1'b1;
            state_r <= RESP;
          end else if (!cache_write && cache_read) begin
            pmem_read_r    <= 1'b1;
            pmem_address_r <= {req_tag_s, {S_OFFSET{1'b0}}};
            state_r        <= MEM_READ;
          end else if (!empty_s) begin
            // Also reached by a write miss on a full buffer: free the head first.
            pmem_write_r   <= 1'b1;
            pmem_address_r <= {tag_r[head_r], {S_OFFSET{1'b0}}};
            pmem_wdata_r   <= data_r[head_r];
            state_r        <= DRAIN;
          end
        end
        RESP: begin
          resp_r  <= 1'b0;
          state_r <= IDLE;
        end
        MEM_READ: begin
          if (pmem_resp) begin
            pmem_read_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            pmem_write_r    <= 1'b0;
            valid_r[head_r] <= 1'b0;
            head_r          <= head_r + 1'b1;
            count_r         <= count_r - 1'b1;
            state_r         <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign cache_resp   = resp_r | ((state_r == MEM_READ) & pmem_resp);
  assign cache_rdata  = (state_r == MEM_READ) ? pmem_rdata : rdata_r;
  assign pmem_read    = pmem_read_r;
  assign pmem_write   = pmem_write_r;
  assign pmem_address = pmem_address_r;
  assign pmem_wdata   = pmem_wdata_r;

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Directed bench for dcache_victim_buffer: inputs change away from the rising edge,
// outputs are checked 1 time unit after it (or mid-cycle for combinational paths).
module tb_dcache_victim_buffer;

  logic         clk;
  logic         rst;
  logic [31:0]  cache_address;
  logic         cache_read;
  logic         cache_write;
  logic [255:0] cache_wdata;
  logic [255:0] cache_rdata;
  logic         cache_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] DATA_A = {32{8'hA5}};
  localparam logic [255:0] DATA_B = {32{8'h3C}};
  localparam logic [255:0] DATA_C = {32{8'hC3}};
  localparam logic [255:0] DATA_D = {32{8'hD4}};

  dcache_victim_buffer #(.DEPTH(4), .S_OFFSET(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .cache_address(cache_address),
    .cache_read   (cache_read),
    .cache_write  (cache_write),
    .cache_wdata  (cache_wdata),
    .cache_rdata  (cache_rdata),
    .cache_resp   (cache_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) begin
    assert (!(rst && cache_read && cache_write)) else begin
      errors++;
      $error("FAIL illegal_req: cache_read and cache_write both 1");
    end
    assert (!(pmem_read && pmem_write)) else begin
      errors++;
      $error("FAIL pmem_excl: pmem_read and pmem_write both 1");
    end
  end

  function automatic logic [255:0] line_data(input logic [31:0] a);
    return {8{a}};
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted eviction: no resp while sampled, resp in the next cycle, then single pulse.
  task automatic write_line(input logic [31:0] a, input logic [255:0] d, input string tag);
    @(negedge clk);
    cache_write   = 1'b1;
    cache_read    = 1'b0;
    cache_address = a;
    cache_wdata   = d;
    #1 chk_bit({tag, " resp_c1"}, cache_resp, 1'b0);
    tick();
    chk_bit({tag, " resp_c2"}, cache_resp, 1'b1);
    chk_bit({tag, " no_pmem_write"}, pmem_write, 1'b0);
    tick();
    chk_bit({tag, " resp_once"}, cache_resp, 1'b0);
  endtask

  task automatic wait_write(input string tag);
    int n = 0;
    while (pmem_write !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk_bit({tag, " pmem_write"}, pmem_write, 1'b1);
  endtask

  task automatic expect_drain(input logic [31:0] a, input logic [255:0] d, input string tag);
    wait_write(tag);
    chk_addr({tag, " addr"}, pmem_address, a);
    chk_vec({tag, " wdata"}, pmem_wdata, d);
    chk_bit({tag, " no_read"}, pmem_read, 1'b0);
    @(negedge clk);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk_bit({tag, " write_drop"}, pmem_write, 1'b0);
  endtask

  initial begin
    rst           = 1'b0;
    cache_address = 32'h0000_0000;
    cache_read    = 1'b0;
    cache_write   = 1'b0;
    cache_wdata   = 256'h0;
    pmem_rdata    = 256'h0;
    pmem_resp     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst cache_resp", cache_resp, 1'b0);
    chk_bit("rst pmem_read", pmem_read, 1'b0);
    chk_bit("rst pmem_write", pmem_write, 1'b0);
    chk_addr("rst pmem_address", pmem_address, 32'h0000_0000);
    chk_vec("rst pmem_wdata", pmem_wdata, 256'h0);
    chk_vec("rst cache_rdata", cache_rdata, 256'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1: eviction absorbed, read hit served from buffer, later drained when idle
    write_line(32'h0000_1040, DATA_A, "t1 wr");
    @(negedge clk);
    cache_write = 1'b0;
    cache_read  = 1'b1;
    tick();
    chk_bit("t1 rd resp", cache_resp, 1'b1);
    chk_vec("t1 rd data", cache_rdata, DATA_A);
    chk_bit("t1 rd no_pmem_read", pmem_read, 1'b0);
    cache_read = 1'b0;
    tick();
    chk_bit("t1 rd resp_once", cache_resp, 1'b0);
    expect_drain(32'h0000_1040, DATA_A, "t1 drain");

    // 2: read miss forwarded to memory, response passes straight through
    @(negedge clk);
    cache_read    = 1'b1;
    cache_address = 32'h0000_2000;
    tick();
    chk_bit("t2 pmem_read", pmem_read, 1'b1);
    chk_addr("t2 addr", pmem_address, 32'h0000_2000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bit("t2 hold pmem_read", pmem_read, 1'b1);
      chk_bit("t2 hold no_resp", cache_resp, 1'b0);
    end
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = DATA_B;
    #1;
    chk_bit("t2 resp", cache_resp, 1'b1);
    chk_vec("t2 rdata", cache_rdata, DATA_B);
    tick();
    cache_read = 1'b0;
    pmem_resp  = 1'b0;
    chk_bit("t2 read_drop", pmem_read, 1'b0);
    chk_bit("t2 resp_drop", cache_resp, 1'b0);
    tick();
    tick();
    chk_bit("t2 count0 no_drain", pmem_write, 1'b0);

    // 3: fill to DEPTH, fifth eviction forces a drain of the oldest line first
    write_line(32'h0000_0100, line_data(32'h0000_0100), "t3 wr100");
    write_line(32'h0000_0200, line_data(32'h0000_0200), "t3 wr200");
    write_line(32'h0000_0300, line_data(32'h0000_0300), "t3 wr300");
    write_line(32'h0000_0400, line_data(32'h0000_0400), "t3 wr400");
    @(negedge clk);
    cache_address = 32'h0000_0500;
    cache_wdata   = line_data(32'h0000_0500);
    tick();
    chk_bit("t3 full drain", pmem_write, 1'b1);
    chk_addr("t3 full addr", pmem_address, 32'h0000_0100);
    chk_vec("t3 full wdata", pmem_wdata, line_data(32'h0000_0100));
    chk_bit("t3 full no_resp", cache_resp, 1'b0);
    tick();
    chk_bit("t3 drain no_resp", cache_resp, 1'b0);
    @(negedge clk);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk_bit("t3 pop write_drop", pmem_write, 1'b0);
    chk_bit("t3 pop no_resp", cache_resp, 1'b0);
    tick();
    chk_bit("t3 wr500 resp", cache_resp, 1'b1);
    cache_write = 1'b0;
    tick();
    expect_drain(32'h0000_0200, line_data(32'h0000_0200), "t3 d200");
    expect_drain(32'h0000_0300, line_data(32'h0000_0300), "t3 d300");
    expect_drain(32'h0000_0400, line_data(32'h0000_0400), "t3 d400");
    expect_drain(32'h0000_0500, line_data(32'h0000_0500), "t3 d500");
    tick();
    tick();
    chk_bit("t3 empty", pmem_write, 1'b0);

    // 4: rewrite of a buffered line merges in place, one drain with newest data
    write_line(32'h0000_0300, DATA_C, "t4 wrC");
    write_line(32'h0000_0300, DATA_D, "t4 wrD");
    cache_write = 1'b0;
    expect_drain(32'h0000_0300, DATA_D, "t4 drain");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit("t4 single_drain", pmem_write, 1'b0);
    end

    // 5: reset mid-drain discards the buffer; a previously buffered line misses
    write_line(32'h0000_0700, line_data(32'h0000_0700), "t5 wr700");
    write_line(32'h0000_0800, line_data(32'h0000_0800), "t5 wr800");
    write_line(32'h0000_0900, line_data(32'h0000_0900), "t5 wr900");
    cache_write = 1'b0;
    wait_write("t5 drain");
    chk_addr("t5 drain addr", pmem_address, 32'h0000_0700);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bit("t5 async write_drop", pmem_write, 1'b0);
    chk_addr("t5 async addr", pmem_address, 32'h0000_0000);
    chk_vec("t5 async wdata", pmem_wdata, 256'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cache_read    = 1'b1;
    cache_address = 32'h0000_0800;
    tick();
    chk_bit("t5 miss pmem_read", pmem_read, 1'b1);
    chk_addr("t5 miss addr", pmem_address, 32'h0000_0800);
    chk_bit("t5 miss no_resp", cache_resp, 1'b0);
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = line_data(32'h0000_0800);
    #1;
    chk_bit("t5 miss resp", cache_resp, 1'b1);
    tick();
    cache_read = 1'b0;
    pmem_resp  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit("t5 count0 no_drain", pmem_write, 1'b0);
    end

    // 6: read arriving mid-drain waits for the pop, then beats the remaining drains
    write_line(32'h0000_0100, line_data(32'h0000_0100), "t6 wr100");
    write_line(32'h0000_0200, line_data(32'h0000_0200), "t6 wr200");
    cache_write = 1'b0;
    wait_write("t6 drain");
    chk_addr("t6 drain addr", pmem_address, 32'h0000_0100);
    @(negedge clk);
    cache_read    = 1'b1;
    cache_address = 32'h0000_0600;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_bit("t6 wait no_read", pmem_read, 1'b0);
      chk_bit("t6 wait write", pmem_write, 1'b1);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk_bit("t6 pop write_drop", pmem_write, 1'b0);
    chk_bit("t6 pop no_read", pmem_read, 1'b0);
    tick();
    chk_bit("t6 read first", pmem_read, 1'b1);
    chk_addr("t6 read addr", pmem_address, 32'h0000_0600);
    chk_bit("t6 read no_write", pmem_write, 1'b0);
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = DATA_B;
    #1;
    chk_bit("t6 read resp", cache_resp, 1'b1);
    chk_vec("t6 read rdata", cache_rdata, DATA_B);
    tick();
    cache_read = 1'b0;
    pmem_resp  = 1'b0;
    expect_drain(32'h0000_0200, line_data(32'h0000_0200), "t6 d200");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
